// File: rtl/pwm_plane_ctrl_if.sv
// MCU byte-bus interface of the PWM plane controller: data/command byte,
// falling-edge write strobe, register select and write acknowledge.
interface pwm_plane_ctrl_if #(
    parameter int D_WIDTH = 8
) ();
    logic [D_WIDTH-1:0] data_in;
    logic               data_en;
    logic               rs;
    logic               wr_ack;

    modport master (output data_in, output data_en, output rs, input wr_ack);
    modport slave  (input data_in, input data_en, input rs, output wr_ack);
endinterface

// File: rtl/pwm_plane_ctrl.sv
// Double-buffered PWM plane controller: MCU strobes fill a shadow duty buffer
// that is copied to the active buffer only at a PWM period boundary.
module pwm_plane_ctrl #(
    parameter int OUT_NUM     = 64,
    parameter int D_WIDTH     = 8,
    parameter int C_WIDTH     = 5,
    parameter int PWM_PERIOD  = 29,
    parameter int MCU_CLK_DIV = 2
) (
    input  logic               clk,
    input  logic               reset,
    pwm_plane_ctrl_if.slave    mcu,
    output logic [OUT_NUM-1:0] pwm_out,
    output logic               mcu_clk,
    output logic               frame_start
);
    localparam int AW = D_WIDTH - 1;
    localparam int IW = (OUT_NUM > 1) ? $clog2(OUT_NUM) : 1;

    logic               enQ;
    logic               wrQ;
    logic               rsQ;
    logic [D_WIDTH-1:0] cmdQ;
    logic [AW-1:0]      addr;
    logic               incDec;
    logic               pwmEn;
    logic               swapPending;
    logic [C_WIDTH-1:0] cnt;
    logic [C_WIDTH-1:0] shadow [OUT_NUM];
    logic [C_WIDTH-1:0] active [OUT_NUM];
    logic               atTerm;
    logic               swapNow;

    assign atTerm     = (cnt == C_WIDTH'(PWM_PERIOD));
    assign swapNow    = atTerm && swapPending;
    assign mcu.wr_ack = wrQ;
    assign mcu_clk    = cnt[MCU_CLK_DIV];

    always_ff @(posedge clk) begin
        if (!reset) begin
            enQ         <= 1'b0;
            wrQ         <= 1'b0;
            rsQ         <= 1'b0;
            cmdQ        <= '0;
            addr        <= '0;
            incDec      <= 1'b0;
            pwmEn       <= 1'b0;
            swapPending <= 1'b0;
            cnt         <= '0;
            frame_start <= 1'b0;
            pwm_out     <= '0;
            for (int unsigned i = 0; i < OUT_NUM; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            enQ <= mcu.data_en;
            wrQ <= enQ & ~mcu.data_en;
            if (enQ && !mcu.data_en) begin
                cmdQ <= mcu.data_in;
                rsQ  <= mcu.rs;
            end

            cnt         <= atTerm ? '0 : cnt + 1'b1;
            frame_start <= swapNow;
            // Swap copies pre-edge shadow; a swap command on this edge re-arms below.
            if (swapNow) begin
                active      <= shadow;
                swapPending <= 1'b0;
            end

            for (int unsigned i = 0; i < OUT_NUM; i++)
                pwm_out[i] <= pwmEn & (cnt < active[i]);

            if (wrQ) begin
                if (rsQ) begin
                    if (cmdQ[D_WIDTH-1]) begin
                        addr <= cmdQ[AW-1:0];
                    end else if (cmdQ[D_WIDTH-2:5] == '0) begin
                        if (cmdQ[4])
                            swapPending <= 1'b1;
                        else if (cmdQ[3])
                            pwmEn <= cmdQ[2];
                        else if (cmdQ[2])
                            incDec <= cmdQ[0];
                        else if (cmdQ[1])
                            addr <= '0;
                        else if (cmdQ[0])
                            for (int unsigned i = 0; i < OUT_NUM; i++)
                                shadow[i] <= '0;
                    end
                end else begin
                    if (32'(addr) < OUT_NUM)
                        shadow[addr[IW-1:0]] <= cmdQ[C_WIDTH-1:0];
                    addr <= incDec ? addr + 1'b1 : addr - 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_pwm_plane_ctrl.sv
// Directed self-checking bench for pwm_plane_ctrl with hand-computed duty counts.
module tb_pwm_plane_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] pwm_out;
    logic        mcu_clk;
    logic        frame_start;

    int nChecks = 0;
    int nFails  = 0;
    int hiCnt[64];
    int anyHi, fsCnt, ackCnt, fsPhase;
    int tbCnt;

    pwm_plane_ctrl_if #(.D_WIDTH(8)) mcu ();

    pwm_plane_ctrl #(
        .OUT_NUM(64), .D_WIDTH(8), .C_WIDTH(5), .PWM_PERIOD(29), .MCU_CLK_DIV(2)
    ) dut (
        .clk(clk), .reset(reset), .mcu(mcu),
        .pwm_out(pwm_out), .mcu_clk(mcu_clk), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Independent reference for the PWM counter phase
    always @(posedge clk) begin
        if (!reset) tbCnt <= 0;
        else        tbCnt <= (tbCnt == 29) ? 0 : tbCnt + 1;
    end

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Called just after an edge with data_en low; returns just after the execute edge.
    task automatic mcuWrite(input logic rsv, input logic [7:0] val);
        mcu.data_en = 1'b1;
        @(posedge clk); #1;
        mcu.data_en = 1'b0;
        mcu.rs      = rsv;
        mcu.data_in = val;
        @(posedge clk); #1;
        checkEq("ack_hi", mcu.wr_ack, 1);
        @(posedge clk); #1;
        checkEq("ack_lo", mcu.wr_ack, 0);
    endtask

    task automatic window(input int cycles);
        for (int i = 0; i < 64; i++) hiCnt[i] = 0;
        anyHi = 0; fsCnt = 0; ackCnt = 0; fsPhase = -1;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 64; i++) hiCnt[i] += int'(pwm_out[i]);
            if (pwm_out != '0) anyHi++;
            if (frame_start) begin
                fsCnt++;
                if (fsPhase < 0) fsPhase = tbCnt;
            end
            ackCnt += int'(mcu.wr_ack);
        end
    endtask

    task automatic waitFrame(input string tag, output int n);
        logic found;
        found = 1'b0;
        n = 0;
        while (!found && n < 45) begin
            @(posedge clk); #1;
            n++;
            if (frame_start) found = 1'b1;
        end
        checkEq(tag, found, 1);
    endtask

    task automatic waitCnt(input int v);
        int k;
        k = 0;
        while (tbCnt != v && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] mclk;
        int n;
        logic seen;

        reset = 1'b0;
        mcu.data_en = 1'b0;
        mcu.rs = 1'b0;
        mcu.data_in = '0;

        // Reset values and divided MCU clock
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        checkEq("rst_pwm", pwm_out, 0);
        checkEq("rst_ack", mcu.wr_ack, 0);
        checkEq("rst_frame", frame_start, 0);
        mclk[0] = mcu_clk;
        for (int k = 1; k < 8; k++) begin
            @(posedge clk); #1;
            mclk[k] = mcu_clk;
        end
        checkEq("mcu_clk_div", mclk, 8'hF0);
        window(30);
        checkEq("rst_pwm_idle", anyHi, 0);

        // Decrementing writes, enable, swap
        mcuWrite(1'b1, 8'h85);
        mcuWrite(1'b0, 8'd10);
        mcuWrite(1'b0, 8'd20);
        mcuWrite(1'b1, 8'h0C);
        mcuWrite(1'b1, 8'h10);
        window(60);
        checkEq("swap_frame_once", fsCnt, 1);
        checkEq("swap_frame_phase", fsPhase, 0);
        window(30);
        checkEq("duty_ch5", hiCnt[5], 10);
        checkEq("duty_ch4", hiCnt[4], 20);
        checkEq("duty_ch0_off", hiCnt[0], 0);
        checkEq("no_extra_frame", fsCnt, 0);

        // Increment, out-of-range drop at 127, wrap to 0
        mcuWrite(1'b1, 8'h05);
        mcuWrite(1'b1, 8'hFF);
        mcuWrite(1'b0, 8'd7);
        mcuWrite(1'b0, 8'd9);
        mcuWrite(1'b0, 8'd3);
        mcuWrite(1'b1, 8'h10);
        window(60);
        window(30);
        checkEq("wrap_ch0", hiCnt[0], 9);
        checkEq("wrap_ch1", hiCnt[1], 3);
        checkEq("oor_dropped_ch63", hiCnt[63], 0);
        checkEq("keep_ch5", hiCnt[5], 10);

        // Tear-free: shadow write without swap leaves output alone
        mcuWrite(1'b1, 8'h80);
        mcuWrite(1'b0, 8'd31);
        window(90);
        checkEq("tearfree_ch0", hiCnt[0], 27);
        mcuWrite(1'b1, 8'h10);
        waitFrame("tearfree_frame", n);
        window(30);
        checkEq("full_on_ch0", hiCnt[0], 30);

        // Clear executed on the swap edge
        waitCnt(5);
        mcuWrite(1'b1, 8'h10);
        waitCnt(27);
        mcuWrite(1'b1, 8'h01);
        checkEq("clear_edge_frame", frame_start, 1);
        window(30);
        checkEq("clear_keep_ch0", hiCnt[0], 30);
        checkEq("clear_keep_ch1", hiCnt[1], 3);
        checkEq("clear_keep_ch4", hiCnt[4], 20);
        checkEq("clear_keep_ch5", hiCnt[5], 10);
        // Swap request landing on the boundary edge is deferred one period
        waitCnt(27);
        mcuWrite(1'b1, 8'h10);
        checkEq("edge_swap_not_taken", frame_start, 0);
        waitFrame("deferred_frame", n);
        checkEq("deferred_swap_gap", n, 30);
        window(30);
        checkEq("cleared_all_low", anyHi, 0);

        // Reset mid-operation with a coinciding strobe
        mcuWrite(1'b1, 8'h80);
        mcuWrite(1'b0, 8'd12);
        mcuWrite(1'b1, 8'h10);
        waitFrame("pre_rst_frame", n);
        waitCnt(2);
        mcuWrite(1'b1, 8'h10);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (pwm_out[0]) seen = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        checkEq("pre_rst_pwm_on", seen, 1);
        mcu.data_en = 1'b1;
        mcu.rs = 1'b0;
        mcu.data_in = 8'd15;
        @(posedge clk); #1;
        mcu.data_en = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        checkEq("rst_mid_pwm_low", pwm_out, 0);
        checkEq("rst_mid_ack", mcu.wr_ack, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        window(40);
        checkEq("rst_strobe_no_ack", ackCnt, 0);
        checkEq("rst_pending_lost", fsCnt, 0);
        checkEq("rst_outputs_low", anyHi, 0);
        mcuWrite(1'b1, 8'h0C);
        mcuWrite(1'b1, 8'h10);
        waitFrame("post_rst_frame", n);
        window(30);
        checkEq("rst_strobe_no_write", anyHi, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
